// File: rtl/mcp_bus_sync.sv
// rtl/mcp_bus_sync.sv - multi-cycle-path bus synchroniser with valid/ack hold and sticky overrun
module mcp_bus_sync #(
    parameter int BusWidth  = 8,
    parameter int NumStages = 2,
    parameter int PulseMode = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [BusWidth-1:0] UnsyncBus,
    input  logic                BusEnable,
    input  logic                ReadAck,
    output logic [BusWidth-1:0] SyncBus,
    output logic                EnablePulse,
    output logic                DataValid,
    output logic                Overrun
);

    logic [NumStages-1:0] r_sync_chain;
    logic                 r_prev_en;
    logic [BusWidth-1:0]  r_sync_bus;
    logic                 r_enable_pulse;
    logic                 r_data_valid;
    logic                 r_overrun;
    logic                 w_sync_en;
    logic                 w_edge_det;

    assign w_sync_en = r_sync_chain[NumStages-1];

    // Level mode reacts only to the rising edge; toggle mode treats every transition as an event.
    generate
        if (PulseMode != 0) begin : g_toggle
            assign w_edge_det = w_sync_en ^ r_prev_en;
        end else begin : g_level
            assign w_edge_det = w_sync_en & ~r_prev_en;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync_chain <= '0;
            r_prev_en    <= 1'b0;
        end else begin
            r_sync_chain <= {r_sync_chain[NumStages-2:0], BusEnable};
            r_prev_en    <= w_sync_en;
        end
    end

    // The bus is only sampled on the detected edge, so it never needs its own synchronisers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync_bus     <= '0;
            r_enable_pulse <= 1'b0;
        end else begin
            r_enable_pulse <= w_edge_det;
            if (w_edge_det) begin
                r_sync_bus <= UnsyncBus;
            end
        end
    end

    // An ack coinciding with a new capture consumes the old word, so no overrun is flagged.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_edge_det) begin
                r_data_valid <= 1'b1;
            end else if (ReadAck) begin
                r_data_valid <= 1'b0;
            end
            if (w_edge_det && r_data_valid && !ReadAck) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign SyncBus     = r_sync_bus;
    assign EnablePulse = r_enable_pulse;
    assign DataValid   = r_data_valid;
    assign Overrun     = r_overrun;

endmodule
